// File: rtl/event_indicator_pkg.sv
// Shared definitions for the event indicator: per-channel state encodings,
// default channel count and a sizing helper for the blink counter.
package event_indicator_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  localparam int unsigned CH_DEFAULT = 5;

  // Blink counter only has to reach BLINKS-1; keep at least one bit.
  function automatic int unsigned blink_w(input int unsigned blinks);
    return (blinks > 1) ? int'($clog2(blinks)) : 1;
  endfunction

endpackage

// File: rtl/event_indicator_channel.sv
// One LED channel: stretches a single-cycle event into BLINKS flashes of
// ON_TIME cycles lit, separated by OFF_TIME cycles dark.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no sequence running, LED dark, busy low
// ST_ON   | flash in progress, LED lit, cnt counts down the lit time
// ST_OFF  | gap between flashes, LED dark, cnt counts down the gap
module indicator_channel
  import event_indicator_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ON_TIME  = 5_000_000,
  parameter int unsigned OFF_TIME = 5_000_000,
  parameter int unsigned BLINKS   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic event_i,
  output logic led_o,
  output logic busy_o
);

  localparam int unsigned BLINK_W = blink_w(BLINKS);

  localparam logic [CNT_W-1:0]   ON_LOAD    = CNT_W'(ON_TIME - 1);
  localparam logic [CNT_W-1:0]   OFF_LOAD   = CNT_W'(OFF_TIME - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINKS - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [BLINK_W-1:0] blink;

  // Sequence FSM; an event restarts the full sequence from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      blink  <= '0;
      led_o  <= 1'b0;
      busy_o <= 1'b0;
    end else if (event_i) begin
      state  <= ST_ON;
      cnt    <= ON_LOAD;
      blink  <= '0;
      led_o  <= 1'b1;
      busy_o <= 1'b1;
    end else begin
      case (state)
        ST_ON: begin
          if (cnt == '0) begin
            led_o <= 1'b0;
            if (blink == BLINK_LAST) begin
              // Last flash ends the sequence directly, no trailing gap.
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= ST_OFF;
              cnt   <= OFF_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_OFF: begin
          if (cnt == '0) begin
            state <= ST_ON;
            cnt   <= ON_LOAD;
            blink <= blink + BLINK_W'(1);
            led_o <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          led_o  <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          led_o  <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/event_indicator.sv
// Event indicator top: CH independent LED stretch channels between the
// game FSM event pulses and the board LED pins.
module event_indicator
  import event_indicator_pkg::*;
#(
  parameter int unsigned CH       = CH_DEFAULT,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ON_TIME  = 5_000_000,
  parameter int unsigned OFF_TIME = 5_000_000,
  parameter int unsigned BLINKS   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] event_i,
  output logic [CH-1:0] led_o,
  output logic [CH-1:0] busy_o
);

  // One fully independent channel per event line.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    indicator_channel #(
      .CNT_W   (CNT_W),
      .ON_TIME (ON_TIME),
      .OFF_TIME(OFF_TIME),
      .BLINKS  (BLINKS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .event_i(event_i[k]),
      .led_o  (led_o[k]),
      .busy_o (busy_o[k])
    );
  end

endmodule
